blockmix_salsa8: RTL

//  scrypt BlockMix stage (r=1) for the mining datapath. Sits directly downstream of
//  the first PBKDF2 stage and consumes its 1024-bit output block B.

---
 rtl/blockmix_salsa8.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/blockmix_salsa8.sv
// scrypt BlockMix (r=1): Y0 = Salsa20/8(B1^B0), Y1 = Salsa20/8(Y0^B1).
// One iterative Salsa core is reused for both halves; one round per clock.
module blockmix_salsa8 #(
    parameter int ROUNDS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1023:0] data,
    output logic [1023:0] hash,
    output logic          hash_done,
    output logic          busy
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XOR  = 2'd1,
        S_RND  = 2'd2,
        S_FF   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [511:0]    b0_q, b0_d;
    logic [511:0]    b1_q, b1_d;
    logic [511:0]    y0_q, y0_d;
    logic [511:0]    x_q, x_d;
    logic [511:0]    z_q, z_d;
    logic [1023:0]   hash_q, hash_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            half_q, half_d;
    logic [CNT_W-1:0] rnd_cnt_q, rnd_cnt_d;
    logic [511:0]    mix_s;
    logic [511:0]    sum_s;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // One Salsa round: column round when odd=0, row round when odd=1.
    // Word i of a half lives at h[511-32*i -: 32].
    function automatic logic [511:0] salsa_round(input logic [511:0] h, input logic odd);
        logic [31:0]  w [16];
        logic [511:0] r;
        logic [3:0]   ia, ib, ic, id;
        for (int i = 0; i < 16; i++) begin
            w[i] = h[511-32*i -: 32];
        end
        for (int q = 0; q < 4; q++) begin
            if (odd) begin
                ia = 4'(5 * q);
                ib = 4'(4 * q + ((q + 1) % 4));
                ic = 4'(4 * q + ((q + 2) % 4));
                id = 4'(4 * q + ((q + 3) % 4));
            end else begin
                ia = 4'((5 * q) % 16);
                ib = 4'((5 * q + 4) % 16);
                ic = 4'((5 * q + 8) % 16);
                id = 4'((5 * q + 12) % 16);
            end
            w[ib] = w[ib] ^ rotl(w[ia] + w[id], 7);
            w[ic] = w[ic] ^ rotl(w[ib] + w[ia], 9);
            w[id] = w[id] ^ rotl(w[ic] + w[ib], 13);
            w[ia] = w[ia] ^ rotl(w[id] + w[ic], 18);
        end
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[511-32*i -: 32] = w[i];
        end
        return r;
    endfunction

    function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        end
        return r;
    endfunction

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        y0_d      = y0_q;
        x_d       = x_q;
        z_d       = z_q;
        hash_d    = hash_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        half_d    = half_q;
        rnd_cnt_d = rnd_cnt_q;
        mix_s     = half_q ? (y0_q ^ b1_q) : (b0_q ^ b1_q);
        sum_s     = add_words(x_q, z_q);
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    b0_d    = data[1023:512];
                    b1_d    = data[511:0];
                    half_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_XOR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XOR: begin
                x_d       = mix_s;
                z_d       = mix_s;
                rnd_cnt_d = '0;
                state_d   = S_RND;
            end
            S_RND: begin
                x_d = salsa_round(x_q, rnd_cnt_q[0]);
                if (rnd_cnt_q == LAST_RND) begin
                    state_d = S_FF;
                end else begin
                    rnd_cnt_d = rnd_cnt_q + CNT_W'(1);
                end
            end
            S_FF: begin
                if (!half_q) begin
                    y0_d    = sum_s;
                    half_d  = 1'b1;
                    state_d = S_XOR;
                end else begin
                    // Y0 is only exposed together with Y1, so hash never shows a half result.
                    hash_d  = {y0_q, sum_s};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            b0_q      <= '0;
            b1_q      <= '0;
            y0_q      <= '0;
            x_q       <= '0;
            z_q       <= '0;
            hash_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            half_q    <= 1'b0;
            rnd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            y0_q      <= y0_d;
            x_q       <= x_d;
            z_q       <= z_d;
            hash_q    <= hash_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            half_q    <= half_d;
            rnd_cnt_q <= rnd_cnt_d;
        end
    end

    assign hash      = hash_q;
    assign hash_done = done_q;
    assign busy      = busy_q;

endmodule
